// File: rtl/serial_lut_cell_if.sv
// TinyTapeout-style user slot bundle: 8 input pins and 8 output pins.
// master drives io_in and reads io_out; slave (the cell) does the opposite.
interface serial_lut_cell_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/serial_lut_cell.sv
// Serially programmable 3-input LUT cell with daisy-chain read-back.
// Ports: bus.io_in = {in2,in1,in0, sin, ce_n, sclk, reset, clk};
//        bus.io_out = {sout, frame_active, committed, bit_cnt[2:0],
//                      lut_reg, lut_comb}.
module serial_lut_cell #(
    parameter logic [7:0] LUT_RESET   = 8'h80,
    parameter int         SYNC_STAGES = 2
) (
    serial_lut_cell_if.slave bus
);

    logic       clk;
    logic       rst;
    logic       sclk_pin;
    logic       ce_n_pin;
    logic       sin_pin;
    logic [2:0] idx;

    assign clk      = bus.io_in[0];
    assign rst      = bus.io_in[1];
    assign sclk_pin = bus.io_in[2];
    assign ce_n_pin = bus.io_in[3];
    assign sin_pin  = bus.io_in[4];
    assign idx      = bus.io_in[7:5];

    // synchronizers plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ce_q;
    logic [SYNC_STAGES-1:0] sin_q;
    logic                   sclk_h;
    logic                   ce_h;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '1;
            ce_q   <= '1;
            sin_q  <= '0;
            sclk_h <= 1'b1;
            ce_h   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_pin};
            ce_q   <= {ce_q[SYNC_STAGES-2:0], ce_n_pin};
            sin_q  <= {sin_q[SYNC_STAGES-2:0], sin_pin};
            sclk_h <= sclk_q[SYNC_STAGES-1];
            ce_h   <= ce_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic ce_s;
    logic sin_s;
    logic sclk_rise;
    logic ce_fall;
    logic ce_rise;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign ce_s      = ce_q[SYNC_STAGES-1];
    assign sin_s     = sin_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_h;
    assign ce_fall   = ~ce_s & ce_h;
    assign ce_rise   = ce_s & ~ce_h;

    logic [7:0] active_lut;
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt;
    logic       sout;
    logic       committed;
    logic       lut_reg;
    logic       lut_comb;

    logic [7:0] active_lut_n;
    logic [7:0] shift_reg_n;
    logic [3:0] bit_cnt_n;
    logic       sout_n;
    logic       committed_n;
    logic [7:0] base_sr;
    logic [3:0] base_cnt;

    // A frame start loads the read-back copy first, so a coincident
    // sclk rise shifts the freshly loaded table rather than the old one.
    always_comb begin
        active_lut_n = active_lut;
        shift_reg_n  = shift_reg;
        bit_cnt_n    = bit_cnt;
        sout_n       = sout;
        committed_n  = committed;
        base_sr      = ce_fall ? active_lut : shift_reg;
        base_cnt     = ce_fall ? 4'd0 : bit_cnt;

        if (ce_fall) begin
            shift_reg_n = active_lut;
            bit_cnt_n   = 4'd0;
            committed_n = 1'b0;
        end

        if (sclk_rise && !ce_s) begin
            sout_n      = base_sr[7];
            shift_reg_n = {base_sr[6:0], sin_s};
            bit_cnt_n   = base_cnt[3] ? 4'd8 : base_cnt + 4'd1;
        end

        // short frames are dropped; the table only changes on a full load
        if (ce_rise && bit_cnt[3]) begin
            active_lut_n = shift_reg;
            committed_n  = 1'b1;
        end
    end

    assign lut_comb = active_lut[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            active_lut <= LUT_RESET;
            shift_reg  <= 8'h00;
            bit_cnt    <= 4'd0;
            sout       <= 1'b0;
            committed  <= 1'b0;
            lut_reg    <= 1'b0;
        end else begin
            active_lut <= active_lut_n;
            shift_reg  <= shift_reg_n;
            bit_cnt    <= bit_cnt_n;
            sout       <= sout_n;
            committed  <= committed_n;
            lut_reg    <= lut_comb;
        end
    end

    assign bus.io_out = {sout, ~ce_s, committed, bit_cnt[2:0],
                         lut_reg, lut_comb};

endmodule

// File: tb/tb_serial_lut_cell.sv
// Scoreboard bench for serial_lut_cell.
// Timed expectations checked on negedge.
module tb_serial_lut_cell;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b1;
  logic       ce_n = 1'b1;
  logic       sin  = 1'b0;
  logic [2:0] idx  = 3'd0;
  int         cyc  = 0;
  bit         done = 1'b0;

  serial_lut_cell_if bus ();

  assign bus.io_in =
    {idx, sin, ce_n, sclk, rst, clk};

  serial_lut_cell dut (
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] mask;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic expect_at(
    input int         lat,
    input logic [7:0] mask,
    input logic [7:0] exp,
    input string      name
  );
    exp_t e;
    e.due  = cyc + lat;
    e.mask = mask;
    e.exp  = exp & mask;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 &&
             sb[0].due <= cyc) begin
        exp_t e;
        logic [7:0] got;
        e   = sb.pop_front();
        got = bus.io_out & e.mask;
        total_cnt++;
        if (got === e.exp)
          pass_cnt++;
        else
          $display(
            "FAIL %s: got %02h want %02h",
            e.name, got, e.exp);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: test stalled");
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(
    input logic b,
    input logic exp_sout
  );
    sin  = b;
    sclk = 1'b0;
    step(4);
    sclk = 1'b1;
    expect_at(4, 8'h80,
              {exp_sout, 7'b0}, "sout");
    step(4);
  endtask

  task automatic send_frame(
    input logic [7:0] data,
    input logic [7:0] old_tbl
  );
    ce_n = 1'b0;
    expect_at(4, 8'h40, 8'h40,
              "frame_active");
    step(4);
    for (int i = 7; i >= 0; i--)
      send_bit(data[i], old_tbl[i]);
    ce_n = 1'b1;
    expect_at(4, 8'h7c, 8'h20,
              "commit_status");
    step(6);
  endtask

  logic [7:0] tbl;

  initial begin
    rst = 1'b1;
    idx = 3'b101;
    step(3);
    expect_at(0, 8'hff, 8'h00, "reset_idx5");
    step(2);
    idx = 3'b111;
    expect_at(0, 8'hff, 8'h01, "reset_idx7");
    step(2);
    rst = 1'b0;
    step(3);

    send_frame(8'h96, 8'h80);

    tbl = 8'h96;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      expect_at(0, 8'h01,
                {7'b0, tbl[i]}, "lut_comb");
      expect_at(1, 8'h02,
                {6'b0, tbl[i], 1'b0},
                "lut_reg");
      step(1);
    end
    step(3);

    send_frame(8'hA5, 8'h96);
    idx = 3'd0;
    expect_at(0, 8'h01, 8'h01, "a5_idx0");
    step(1);
    idx = 3'd6;
    expect_at(0, 8'h01, 8'h00, "a5_idx6");
    step(1);

    ce_n = 1'b0;
    expect_at(4, 8'h60, 8'h40, "short_start");
    step(4);
    tbl = 8'hA5;
    for (int i = 7; i >= 3; i--)
      send_bit(1'b0, tbl[i]);
    ce_n = 1'b1;
    expect_at(4, 8'h7c, 8'h14,
              "short_status");
    step(6);
    idx = 3'd0;
    expect_at(0, 8'h01, 8'h01, "short_keep0");
    step(1);
    idx = 3'd1;
    expect_at(0, 8'h01, 8'h00, "short_keep1");
    step(1);
    idx = 3'd5;
    expect_at(0, 8'h01, 8'h01, "short_keep5");
    step(2);

    ce_n = 1'b0;
    step(4);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    rst = 1'b1;
    step(2);
    idx = 3'd5;
    expect_at(0, 8'hff, 8'h00, "midrst_idx5");
    step(1);
    idx = 3'd7;
    expect_at(0, 8'hff, 8'h01, "midrst_idx7");
    step(1);
    ce_n = 1'b1;
    sclk = 1'b1;
    step(4);
    rst = 1'b0;
    idx = 3'd5;
    step(6);
    expect_at(0, 8'hff, 8'h00,
              "post_rst_idle");
    step(8);

    done = 1'b1;
    if (sb.size() != 0)
      $display("FAIL %0d checks never ran",
               sb.size());
    if (pass_cnt != total_cnt)
      $display("FAIL %0d checks failed",
               total_cnt - pass_cnt);
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
